// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//
// Registered ripple-carry adder built from 1-bit full-adder cells. The result
// of iA + iB + iC is captured on a rising iClk when iValid is high. It appears
// on oS/oC one cycle later, qualified by oValid. With WIDTH=1 this is the
// classic single full-adder cell.
//
// Parameters:
//    WIDTH   operand and sum width in bits (1..64)
//
// Ports:
//    iClk    in   1      rising-edge clock
//    iRst    in   1      synchronous active-high reset
//    iA      in   WIDTH  addend A
//    iB      in   WIDTH  addend B
//    iC      in   1      carry-in to bit 0
//    iValid  in   1      operands valid; result captured when 1
//    oS      out  WIDTH  registered sum
//    oC      out  1      registered carry-out of the MSB cell
//    oValid  out  1      registered; one cycle per captured operand set
// ----------------------------------------------------------------------------
module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic             iC,
   input  logic             iValid,
   output logic [WIDTH-1:0] oS,
   output logic             oC,
   output logic             oValid
);

   // One full-adder cell: returns {carry_out, sum}.
   function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic c);
      logic p;
      p = a ^ b;
      return {(a & b) | (c & p), p ^ c};
   endfunction

   logic [WIDTH-1:0] sum_s;
   logic             carry_out_s;
   logic [WIDTH-1:0] sum_r;
   logic             carry_r;
   logic             valid_r;

   // Ripple chain: the carry is walked through a block-local variable so the
   // chain stays a single combinational pass with no self-feedback on a vector.
   always_comb begin
      logic       carry_v;
      logic [1:0] cell_v;
      sum_s   = {WIDTH{1'b0}};
      carry_v = iC;
      cell_v  = 2'b00;
      for (int i = 0; i < WIDTH; i++) begin
         cell_v   = fa_cell(iA[i], iB[i], carry_v);
         sum_s[i] = cell_v[0];
         carry_v  = cell_v[1];
      end
      carry_out_s = carry_v;
   end

   // Output registers: reset wins. The result updates only on valid
   // operands, so inputs are ignored entirely while iValid is low.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         sum_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         valid_r <= iValid;
         if (iValid) begin
            sum_r   <= sum_s;
            carry_r <= carry_out_s;
         end else begin
            sum_r   <= sum_r;
            carry_r <= carry_r;
         end
      end
   end

   assign oS     = sum_r;
   assign oC     = carry_r;
   assign oValid = valid_r;

endmodule

// File: tb/tb_full_adder.sv
// ----------------------------------------------------------------------------
// tb_full_adder
//
// Directed bench for full_adder. It drives a 1-bit instance and an 8-bit
// instance from a shared clock and reset. Inputs change 1 time unit after a
// rising edge. Outputs are checked 1 time unit after the following rising edge.
// ----------------------------------------------------------------------------
module tb_full_adder;

   logic       clk;
   logic       rst;

   logic       a1, b1, c1, v1;
   logic       s1, co1, vo1;

   logic [7:0] a8, b8;
   logic       c8, v8;
   logic [7:0] s8;
   logic       co8, vo8;

   int tests_run;
   int tests_failed;

   full_adder #(.WIDTH(1)) dut1 (
      .iClk(clk), .iRst(rst), .iA(a1), .iB(b1), .iC(c1), .iValid(v1),
      .oS(s1), .oC(co1), .oValid(vo1)
   );

   full_adder #(.WIDTH(8)) dut8 (
      .iClk(clk), .iRst(rst), .iA(a8), .iB(b8), .iC(c8), .iValid(v8),
      .oS(s8), .oC(co8), .oValid(vo8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] exp_sum_tbl [8];

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      exp_sum_tbl  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

      rst = 1'b1;
      a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; v1 = 1'b0;
      a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; v8 = 1'b0;

      // Reset held for two cycles
      for (int k = 0; k < 2; k++) begin
         tick();
         check("rst_s1",  {63'd0, s1},  64'd0);
         check("rst_c1",  {63'd0, co1}, 64'd0);
         check("rst_v1",  {63'd0, vo1}, 64'd0);
         check("rst_s8",  {56'd0, s8},  64'd0);
         check("rst_v8",  {63'd0, vo8}, 64'd0);
      end

      // Release with no valid input: outputs stay cleared
      rst = 1'b0;
      tick();
      check("post_rst_s1", {63'd0, s1},  64'd0);
      check("post_rst_c1", {63'd0, co1}, 64'd0);
      check("post_rst_v1", {63'd0, vo1}, 64'd0);

      // All eight 1-bit combinations, back to back
      v1 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         {a1, b1, c1} = 3'(k);
         tick();
         check($sformatf("truth_%0d", k), {62'd0, co1, s1}, {62'd0, exp_sum_tbl[k]});
         check($sformatf("truth_v_%0d", k), {63'd0, vo1}, 64'd1);
      end

      // Capture 1+1+0, then hold while inputs toggle (including X) with valid low
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
      tick();
      check("cap_s", {63'd0, s1},  64'd0);
      check("cap_c", {63'd0, co1}, 64'd1);
      v1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a1 = ~a1; b1 = (k == 1) ? 1'bx : ~b1; c1 = ~c1;
         tick();
         check($sformatf("hold_s_%0d", k), {63'd0, s1},  64'd0);
         check($sformatf("hold_c_%0d", k), {63'd0, co1}, 64'd1);
         check($sformatf("hold_v_%0d", k), {63'd0, vo1}, 64'd0);
      end
      b1 = 1'b0;

      // 8-bit vectors
      v8 = 1'b1;
      a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
      tick();
      check("w8_ff_00_1_s", {56'd0, s8},  64'h00);
      check("w8_ff_00_1_c", {63'd0, co8}, 64'd1);
      check("w8_ff_00_1_v", {63'd0, vo8}, 64'd1);
      a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
      tick();
      check("w8_ff_ff_1_s", {56'd0, s8},  64'hFF);
      check("w8_ff_ff_1_c", {63'd0, co8}, 64'd1);
      a8 = 8'h3C; b8 = 8'h41; c8 = 1'b0;
      tick();
      check("w8_3c_41_0_s", {56'd0, s8},  64'h7D);
      check("w8_3c_41_0_c", {63'd0, co8}, 64'd0);
      v8 = 1'b0;
      tick();
      check("w8_v_drop", {63'd0, vo8}, 64'd0);
      check("w8_hold_s", {56'd0, s8},  64'h7D);

      // Reset mid-stream: valid 1+1+1 on the same edge as reset is discarded
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
      rst = 1'b1;
      tick();
      check("mid_rst_s", {63'd0, s1},  64'd0);
      check("mid_rst_c", {63'd0, co1}, 64'd0);
      check("mid_rst_v", {63'd0, vo1}, 64'd0);
      rst = 1'b0; v1 = 1'b0;
      tick();
      check("after_rst_s", {63'd0, s1},  64'd0);
      check("after_rst_c", {63'd0, co1}, 64'd0);
      check("after_rst_v", {63'd0, vo1}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered full adder: sums operand iA, operand iB and carry-in iC, and presents sum oS and carry-out oC one clock after capture.
- Default WIDTH=1 is the classic 1-bit full-adder cell. Wider settings form an internal ripple chain of 1-bit cells.
- Used as the arithmetic leaf in datapaths that need a pipelined add stage with a valid qualifier.

Parameters:
WIDTH, 1, operand and sum width in bits (legal range 1..64)

Ports:
iClk  input  1  rising-edge clock; all state updates on this edge only
iRst  input  1  synchronous reset, active-high, sampled on rising iClk
iA  input  WIDTH  addend A
iB  input  WIDTH  addend B
iC  input  1  carry-in to bit 0
iValid  input  1  operands valid this cycle; result captured when 1
oS  output  WIDTH  registered sum
oC  output  1  registered carry-out from MSB cell
oValid  output  1  registered; 1 for exactly one cycle per captured operand set

Behaviour:
- Interface is fixed: one clock iClk; iRst is synchronous and active-high.
- Reset:
  - On a rising iClk with iRst=1: oS=0, oC=0, oValid=0.
  - Reset has priority over iValid.
  - A sum in flight when reset asserts is discarded.
- Cell equations per bit i, with c0=iC:
  - s_i = a_i ^ b_i ^ c_i
  - c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i))
  - oC = c_WIDTH
- Arithmetic:
  - {oC,oS} equals unsigned iA + iB + iC, computed modulo 2^(WIDTH+1); no truncation beyond that.
  - All-ones + all-ones + 1 gives oS=all-ones, oC=1.
- Capture and latency:
  - On a rising iClk with iRst=0 and iValid=1: oS, oC take the combinational result of the current iA/iB/iC. Latency is 1 cycle.
  - With iRst=0 and iValid=0: oS and oC hold their previous values.
- oValid:
  - oValid <= iValid every non-reset cycle, so back-to-back valid inputs give back-to-back valid outputs.
  - No backpressure and no stall input.
- No combinational path from any input to any output; all outputs come straight from flops.
- X/Z on inputs while iValid=0 must not disturb the outputs.

Test Plan:
- WIDTH=1, iRst=1 for 2 cycles, then release -> oS=0, oC=0, oValid=0 during and immediately after reset.
- WIDTH=1, iValid=1, apply all 8 {iA,iB,iC} combinations 000..111, one per cycle -> next-cycle {oC,oS} = 00,01,01,10,01,10,10,11, with oValid=1 each cycle.
- WIDTH=1, capture iA=1,iB=1,iC=0, then iValid=0 while iA/iB/iC toggle for 3 cycles -> oS=0, oC=1 held, oValid=0.
- WIDTH=8: iA=0xFF, iB=0x00, iC=1 -> oS=0x00, oC=1. iA=0xFF, iB=0xFF, iC=1 -> oS=0xFF, oC=1. iA=0x3C, iB=0x41, iC=0 -> oS=0x7D, oC=0.
- Reset mid-stream: valid operands 1,1,1 presented on the same edge iRst=1 -> oS=0, oC=0, oValid=0 next cycle; the result is never emitted.
